// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flushes and data-memory wait holds.
// Optional macro FORWARDING_EN restricts stalls to load-use hazards against EXE.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_uses_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             be_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] wait_cnt, wait_n;
    logic [3:0] fl_cnt, fl_n;

    logic mem_stall;
    logic hazard;
    logic exe_match;
    logic mem_match;
    logic timeout_hit;
    logic flush_now;

    assign mem_stall = mem_req & ~mem_ready;

    assign exe_match = exe_wb_en &
                       ((id_uses_src & (src1 == exe_dest)) |
                        (two_src & (src2 == exe_dest)));
    assign mem_match = mem_wb_en &
                       ((id_uses_src & (src1 == mem_dest)) |
                        (two_src & (src2 == mem_dest)));

`ifdef FORWARDING_EN
    // MEM-stage results reach ID through the forwarding unit; only loads stall.
    logic unused_mem_match;
    assign unused_mem_match = mem_match;
    assign hazard = exe_mem_r_en & exe_match;
`else
    logic unused_mem_r_en;
    assign unused_mem_r_en = exe_mem_r_en;
    assign hazard = exe_match | mem_match;
`endif

    assign timeout_hit = (state == MEM_WAIT) && mem_stall &&
                         (wait_cnt == 8'(MEM_TIMEOUT));
    assign flush_now   = (state == BR_FLUSH) || branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            fl_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            fl_cnt   <= fl_n;
            if (freeze && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        fl_n    = fl_cnt;
        unique case (state)
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (timeout_hit)
                        state_n = RUN;
                    else
                        wait_n = wait_cnt + 8'd1;
                end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_n = BR_FLUSH;
                    fl_n    = 4'(FLUSH_CYCLES - 1);
                end else begin
                    state_n = RUN;
                end
            end
            BR_FLUSH: begin
                // A memory hold freezes the flush window in place.
                if (!mem_stall) begin
                    fl_n = fl_cnt - 4'd1;
                    if (fl_cnt == 4'd1)
                        state_n = RUN;
                end
            end
            default: begin
                if (mem_stall) begin
                    state_n = MEM_WAIT;
                    wait_n  = 8'd1;
                end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_n = BR_FLUSH;
                    fl_n    = 4'(FLUSH_CYCLES - 1);
                end
            end
        endcase
    end

    always_comb begin
        freeze      = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        be_freeze   = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            freeze = 1'b0;
        end else if (timeout_hit) begin
            mem_timeout = 1'b1;
        end else if (mem_stall) begin
            freeze    = 1'b1;
            be_freeze = 1'b1;
        end else if (flush_now) begin
            // The hazardous instruction is discarded, so no freeze here.
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            freeze   = 1'b1;
            id_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;
`ifdef FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       src1, src2, exe_dest, mem_dest;
    logic             two_src, id_uses_src, exe_wb_en, exe_mem_r_en;
    logic             mem_wb_en, branch_taken, mem_req, mem_ready;
    logic             freeze, if_flush, id_flush, be_freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(3),
        .MEM_TIMEOUT (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .id_uses_src (id_uses_src),
        .exe_dest    (exe_dest),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .be_freeze   (be_freeze),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ef,
                              input logic eif, input logic eid,
                              input logic ebe, input logic eto);
        check({tag, ".freeze"},      32'(freeze),      32'(ef));
        check({tag, ".if_flush"},    32'(if_flush),    32'(eif));
        check({tag, ".id_flush"},    32'(id_flush),    32'(eid));
        check({tag, ".be_freeze"},   32'(be_freeze),   32'(ebe));
        check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(eto));
    endtask

    task automatic cyc(input string tag, input logic ef, input logic eif,
                       input logic eid, input logic ebe, input logic eto);
        @(negedge clk);
        check_outs(tag, ef, eif, eid, ebe, eto);
        if (ef) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        src1 = '0; src2 = '0; two_src = 0; id_uses_src = 0;
        exe_dest = '0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = '0; mem_wb_en = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        #3;
        check_outs("reset", 0, 0, 0, 0, 0);
        check("reset.stall_cnt", 32'(stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("idle", 0, 0, 0, 0, 0);

        // RAW against EXE then MEM
        src1 = 4'd3; id_uses_src = 1; exe_dest = 4'd3; exe_wb_en = 1;
        cyc("exe_raw", !FWD, 0, !FWD, 0, 0);
        exe_wb_en = 0; mem_dest = 4'd3; mem_wb_en = 1;
        cyc("mem_raw", !FWD, 0, !FWD, 0, 0);
        clear_in();
        cyc("raw_done", 0, 0, 0, 0, 0);
        check("raw.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // load-use stalls in both builds
        src1 = 4'd7; id_uses_src = 1; exe_dest = 4'd7;
        exe_wb_en = 1; exe_mem_r_en = 1;
        cyc("load_use", 1, 0, 1, 0, 0);
        clear_in();
        cyc("after_lu", 0, 0, 0, 0, 0);

        src2 = 4'd5; two_src = 1; mem_dest = 4'd5; mem_wb_en = 1;
        cyc("src2_mem", !FWD, 0, !FWD, 0, 0);
        clear_in();
        src1 = 4'd9; exe_dest = 4'd9; exe_wb_en = 1; exe_mem_r_en = 1;
        cyc("no_use", 0, 0, 0, 0, 0);
        id_uses_src = 1; src1 = 4'd15; exe_dest = 4'd15;
        cyc("r15", 1, 0, 1, 0, 0);
        src1 = 4'd14;
        cyc("near_miss", 0, 0, 0, 0, 0);
        clear_in();
        cyc("idle2", 0, 0, 0, 0, 0);
        check("haz.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // branch with a simultaneous hazard
        branch_taken = 1; id_uses_src = 1; src1 = 4'd4;
        exe_dest = 4'd4; exe_wb_en = 1; exe_mem_r_en = 1;
        cyc("br0", 0, 1, 1, 0, 0);
        branch_taken = 0;
        cyc("br1", 0, 1, 1, 0, 0);
        cyc("br2", 0, 1, 1, 0, 0);
        clear_in();
        cyc("br_done", 0, 0, 0, 0, 0);

        // memory wait with a deferred branch
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 4; i++) cyc("mw", 1, 0, 0, 1, 0);
        mem_ready = 1;
        cyc("mw_ready", 0, 1, 1, 0, 0);
        clear_in();
        cyc("mw_br1", 0, 1, 1, 0, 0);
        cyc("mw_br2", 0, 1, 1, 0, 0);
        cyc("mw_done", 0, 0, 0, 0, 0);

        // timeout
        mem_req = 1;
        for (int i = 0; i < 8; i++) cyc("to_wait", 1, 0, 0, 1, 0);
        cyc("to_pulse", 0, 0, 0, 0, 1);
        cyc("to_restall", 1, 0, 0, 1, 0);
        clear_in();
        cyc("to_done", 0, 0, 0, 0, 0);
        check("to.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // memory hold pauses the flush window
        branch_taken = 1;
        cyc("bf0", 0, 1, 1, 0, 0);
        branch_taken = 0; mem_req = 1;
        cyc("bf_hold", 1, 0, 0, 1, 0);
        cyc("bf_hold", 1, 0, 0, 1, 0);
        mem_req = 0;
        cyc("bf1", 0, 1, 1, 0, 0);
        cyc("bf2", 0, 1, 1, 0, 0);
        cyc("bf_done", 0, 0, 0, 0, 0);
        check("bf.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // async reset in MEM_WAIT
        mem_req = 1;
        cyc("rmw", 1, 0, 0, 1, 0);
        cyc("rmw", 1, 0, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst_async", 0, 0, 0, 0, 0);
        check("rst_async.stall_cnt", 32'(stall_cnt), 0);
        exp_stall = 0;
        mem_req = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_rst", 0, 0, 0, 0, 0);
        check("post_rst.stall_cnt", 32'(stall_cnt), 0);
        mem_req = 1;
        cyc("post_stall", 1, 0, 0, 1, 0);
        mem_req = 0;
        cyc("post_run", 0, 0, 0, 0, 0);
        check("post.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
